// File: rtl/calc_op_sequencer.sv
// Calculator control unit: serial-key unlock, single-command sequencing of
// ALU / result memory / serializer, and result-slot validity tracking.
// Ports:
//   Clk, Reset          rising-edge clock, async active-low reset
//   InputKey            serial unlock/lock key bit (sampled while idle)
//   ValidCmd, ModeSel,  command strobe, mode (0 = compute+tx, 1 = memory),
//   RWMem, Addr         memory direction (1 = write) and slot address
//   MemSize             active memory size (0 or > MEM_DEPTH = full depth)
//   TxDone              serializer completion pulse
//   CalcActive, CalcMode, Busy, MemAddr, MemCount   registered status
//   AluEn, MemWrEn, MemRdEn, SampleData, StartTx, AccErr  one-cycle strobes
module calc_op_sequencer #(
  parameter logic [3:0]  KEY_SEQ   = 4'b1010,
  parameter int unsigned MEM_DEPTH = 8,
  parameter int unsigned ADDR_W    = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              InputKey,
  input  logic              ValidCmd,
  input  logic              ModeSel,
  input  logic              RWMem,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [ADDR_W:0]   MemSize,
  input  logic              TxDone,
  output logic              CalcActive,
  output logic              CalcMode,
  output logic              Busy,
  output logic              AluEn,
  output logic              MemWrEn,
  output logic              MemRdEn,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              SampleData,
  output logic              StartTx,
  output logic [ADDR_W:0]   MemCount,
  output logic              AccErr
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_MEM_WR, S_MEM_RD, S_SAMPLE, S_TX_START, S_TX_WAIT
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           key_q, key_d;
  logic                 active_q, active_d;
  logic                 mode_q, mode_d;
  logic                 busy_q, busy_d;
  logic                 alu_en_q, alu_en_d;
  logic                 mem_wr_q, mem_wr_d;
  logic                 mem_rd_q, mem_rd_d;
  logic                 sample_q, sample_d;
  logic                 start_tx_q, start_tx_d;
  logic                 acc_err_q, acc_err_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [MEM_DEPTH-1:0] valid_q, valid_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic [CNT_W-1:0]     eff_size;
  logic [MEM_DEPTH-1:0] size_mask;
  logic                 cmd_in_range, cmd_hit, addr_q_in_range;
  logic                 wr_commit, rd_commit;

  // Effective memory size, in-range checks and the slot lookup for reads.
  always_comb begin
    eff_size = (MemSize == '0 || MemSize > CNT_W'(MEM_DEPTH)) ? CNT_W'(MEM_DEPTH) : MemSize;
    cmd_in_range    = {1'b0, Addr} < eff_size;
    addr_q_in_range = {1'b0, addr_q} < eff_size;
    cmd_hit   = 1'b0;
    size_mask = '0;
    for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
      size_mask[i] = CNT_W'(i) < eff_size;
      if (ADDR_W'(i) == Addr && valid_q[i]) cmd_hit = 1'b1;
    end
  end

  // Next-state, registered-output and valid-bitmap logic.
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    active_d   = active_q;
    mode_d     = mode_q;
    addr_d     = addr_q;
    alu_en_d   = 1'b0;
    mem_wr_d   = 1'b0;
    mem_rd_d   = 1'b0;
    sample_d   = 1'b0;
    start_tx_d = 1'b0;
    acc_err_d  = 1'b0;
    wr_commit  = 1'b0;
    rd_commit  = 1'b0;
    valid_d    = valid_q;
    count_d    = '0;

    case (state_q)
      S_IDLE: begin
        mode_d = ModeSel;
        if (key_q == KEY_SEQ) begin
          // Key match takes priority over any command in the same cycle.
          active_d = ~active_q;
          key_d    = '0;
        end else begin
          key_d = {key_q[2:0], InputKey};
          if (active_q && ValidCmd) begin
            addr_d = Addr;
            if (!ModeSel || RWMem) begin
              state_d  = S_EXEC;
              alu_en_d = 1'b1;
            end else begin
              state_d = S_MEM_RD;
              if (cmd_in_range && cmd_hit) mem_rd_d  = 1'b1;
              else                         acc_err_d = 1'b1;
            end
          end
        end
      end
      S_EXEC: begin
        if (!mode_q) begin
          state_d  = S_SAMPLE;
          sample_d = 1'b1;
        end else begin
          state_d = S_MEM_WR;
          if (addr_q_in_range) mem_wr_d  = 1'b1;
          else                 acc_err_d = 1'b1;
        end
      end
      S_MEM_WR: begin
        wr_commit = mem_wr_q;
        state_d   = S_IDLE;
      end
      S_MEM_RD: begin
        rd_commit = mem_rd_q;
        if (mem_rd_q) begin
          state_d  = S_SAMPLE;
          sample_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SAMPLE: begin
        state_d    = S_TX_START;
        start_tx_d = 1'b1;
      end
      S_TX_START: state_d = S_TX_WAIT;
      S_TX_WAIT:  if (TxDone) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    // Slot set/clear, then drop slots beyond the current size; count follows.
    for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
      if (ADDR_W'(i) == addr_q) begin
        if (wr_commit) valid_d[i] = 1'b1;
        if (rd_commit) valid_d[i] = 1'b0;
      end
      valid_d[i] = valid_d[i] & size_mask[i];
      count_d    = count_d + CNT_W'(valid_d[i]);
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      key_q      <= '0;
      active_q   <= 1'b0;
      mode_q     <= 1'b0;
      busy_q     <= 1'b0;
      alu_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      sample_q   <= 1'b0;
      start_tx_q <= 1'b0;
      acc_err_q  <= 1'b0;
      addr_q     <= '0;
      valid_q    <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      active_q   <= active_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
      alu_en_q   <= alu_en_d;
      mem_wr_q   <= mem_wr_d;
      mem_rd_q   <= mem_rd_d;
      sample_q   <= sample_d;
      start_tx_q <= start_tx_d;
      acc_err_q  <= acc_err_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
    end
  end

  assign CalcActive = active_q;
  assign CalcMode   = mode_q;
  assign Busy       = busy_q;
  assign AluEn      = alu_en_q;
  assign MemWrEn    = mem_wr_q;
  assign MemRdEn    = mem_rd_q;
  assign MemAddr    = addr_q;
  assign SampleData = sample_q;
  assign StartTx    = start_tx_q;
  assign MemCount   = count_q;
  assign AccErr     = acc_err_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed self-checking bench for calc_op_sequencer.
module tb_calc_op_sequencer;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       InputKey = 1'b0, ValidCmd = 1'b0, ModeSel = 1'b0, RWMem = 1'b0, TxDone = 1'b0;
  logic [2:0] Addr = '0;
  logic [3:0] MemSize = 4'd8;
  logic       CalcActive, CalcMode, Busy, AluEn, MemWrEn, MemRdEn, SampleData, StartTx, AccErr;
  logic [2:0] MemAddr;
  logic [3:0] MemCount;

  int n_chk = 0;
  int n_fail = 0;
  int tx_seen = 0;

  // Strobe vector bit weights: {AluEn,MemWrEn,MemRdEn,SampleData,StartTx,AccErr,Busy}
  localparam logic [6:0] ALU = 7'h40, WR = 7'h20, RD = 7'h10, SMP = 7'h08,
                         TX = 7'h04, ERR = 7'h02, BSY = 7'h01;

  calc_op_sequencer dut (
    .Clk(Clk), .Reset(Reset), .InputKey(InputKey), .ValidCmd(ValidCmd),
    .ModeSel(ModeSel), .RWMem(RWMem), .Addr(Addr), .MemSize(MemSize),
    .TxDone(TxDone), .CalcActive(CalcActive), .CalcMode(CalcMode), .Busy(Busy),
    .AluEn(AluEn), .MemWrEn(MemWrEn), .MemRdEn(MemRdEn), .MemAddr(MemAddr),
    .SampleData(SampleData), .StartTx(StartTx), .MemCount(MemCount), .AccErr(AccErr)
  );

  always #5 Clk = ~Clk;

  function automatic logic [6:0] strb();
    return {AluEn, MemWrEn, MemRdEn, SampleData, StartTx, AccErr, Busy};
  endfunction

  function automatic logic [14:0] outs();
    return {CalcActive, CalcMode, Busy, AluEn, MemWrEn, MemRdEn, MemAddr,
            SampleData, StartTx, MemCount, AccErr};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Shift four key bits MSB first, then one idle cycle for the toggle.
  task automatic send_key(input logic [3:0] k, input logic cmd_on_toggle);
    for (int i = 3; i >= 0; i--) begin
      InputKey = k[i];
      tick();
    end
    InputKey = 1'b0;
    ValidCmd = cmd_on_toggle;
    ModeSel  = 1'b0;
    tick();
    ValidCmd = 1'b0;
  endtask

  task automatic op_mode0(input string tag, input bit finish_tx);
    logic [6:0] exp_seq [4];
    exp_seq = '{ALU | BSY, SMP | BSY, TX | BSY, BSY};
    ValidCmd = 1'b1; ModeSel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      ValidCmd = 1'b0;
      n_chk++;
      if (strb() !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL %s mode0 cycle %0d: strobes got %b expected %b", tag, i + 1, strb(), exp_seq[i]);
      end
      if (i == 0) begin
        n_chk++;
        if (CalcMode !== 1'b0) begin
          n_fail++;
          $display("FAIL %s mode0 CalcMode: got %b expected 0", tag, CalcMode);
        end
      end
    end
    if (finish_tx) begin
      TxDone = 1'b1;
      tick();
      TxDone = 1'b0;
      n_chk++;
      if (strb() !== 7'h00) begin
        n_fail++;
        $display("FAIL %s mode0 after TxDone: strobes got %b expected 0000000", tag, strb());
      end
    end
  endtask

  task automatic op_write(input logic [2:0] a, input bit ok, input string tag);
    logic [6:0] exp_seq [3];
    exp_seq = '{ALU | BSY, (ok ? WR : ERR) | BSY, 7'h00};
    ValidCmd = 1'b1; ModeSel = 1'b1; RWMem = 1'b1; Addr = a;
    for (int i = 0; i < 3; i++) begin
      tick();
      ValidCmd = 1'b0;
      n_chk++;
      if (strb() !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL %s write addr %0d cycle %0d: strobes got %b expected %b", tag, a, i + 1, strb(), exp_seq[i]);
      end
      if (i == 0) begin
        n_chk++;
        if (MemAddr !== a || CalcMode !== 1'b1) begin
          n_fail++;
          $display("FAIL %s write MemAddr/CalcMode: got %0d/%b expected %0d/1", tag, MemAddr, CalcMode, a);
        end
      end
    end
  endtask

  task automatic op_read(input logic [2:0] a, input bit ok, input string tag);
    logic [6:0] exp_seq [5];
    int n;
    if (ok) begin
      exp_seq = '{RD | BSY, SMP | BSY, TX | BSY, BSY, 7'h00};
      n = 5;
    end else begin
      exp_seq = '{ERR | BSY, 7'h00, 7'h00, 7'h00, 7'h00};
      n = 2;
    end
    ValidCmd = 1'b1; ModeSel = 1'b1; RWMem = 1'b0; Addr = a;
    for (int i = 0; i < n; i++) begin
      TxDone = (ok && i == 4);
      tick();
      ValidCmd = 1'b0;
      TxDone = 1'b0;
      if (StartTx === 1'b1) tx_seen++;
      n_chk++;
      if (strb() !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL %s read addr %0d cycle %0d: strobes got %b expected %b", tag, a, i + 1, strb(), exp_seq[i]);
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    tick(); tick();
    n_chk++;
    if (outs() !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0000", outs());
    end
    Reset = 1'b1;
    tick();
    n_chk++;
    if (outs() !== 15'h0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %h expected 0000", outs());
    end
  endtask

  task automatic test_unlock_sample();
    send_key(4'b1010, 1'b0);
    n_chk++;
    if (CalcActive !== 1'b1) begin
      n_fail++;
      $display("FAIL unlock: CalcActive got %b expected 1", CalcActive);
    end
    op_mode0("unlock_sample", 1'b0);
    // Command while busy and extra TX_WAIT cycle: still waiting, nothing fires.
    ValidCmd = 1'b1;
    tick();
    ValidCmd = 1'b0;
    n_chk++;
    if (strb() !== BSY) begin
      n_fail++;
      $display("FAIL cmd_while_busy: strobes got %b expected %b", strb(), BSY);
    end
    TxDone = 1'b1;
    tick();
    TxDone = 1'b0;
    n_chk++;
    if (strb() !== 7'h00) begin
      n_fail++;
      $display("FAIL txdone_to_idle: strobes got %b expected 0000000", strb());
    end
    // TxDone while idle has no effect.
    TxDone = 1'b1;
    tick();
    TxDone = 1'b0;
    tick();
    n_chk++;
    if (strb() !== 7'h00) begin
      n_fail++;
      $display("FAIL txdone_idle: strobes got %b expected 0000000", strb());
    end
  endtask

  task automatic test_key_crossing();
    send_key(4'b1010, 1'b0);
    n_chk++;
    if (CalcActive !== 1'b0) begin
      n_fail++;
      $display("FAIL relock: CalcActive got %b expected 0", CalcActive);
    end
    ValidCmd = 1'b1; ModeSel = 1'b0;
    tick();
    ValidCmd = 1'b0;
    tick();
    n_chk++;
    if (strb() !== 7'h00) begin
      n_fail++;
      $display("FAIL cmd_while_locked: strobes got %b expected 0000000", strb());
    end
    send_key(4'b1011, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    n_chk++;
    if (CalcActive !== 1'b0) begin
      n_fail++;
      $display("FAIL wrong_key: CalcActive got %b expected 0", CalcActive);
    end
    // Command coincident with the key match is dropped.
    send_key(4'b1010, 1'b1);
    n_chk++;
    if (CalcActive !== 1'b1 || strb() !== 7'h00) begin
      n_fail++;
      $display("FAIL key_and_cmd: CalcActive/strobes got %b/%b expected 1/0000000", CalcActive, strb());
    end
    tick();
    n_chk++;
    if (strb() !== 7'h00) begin
      n_fail++;
      $display("FAIL key_and_cmd_after: strobes got %b expected 0000000", strb());
    end
    send_key(4'b1010, 1'b0);
    n_chk++;
    if (CalcActive !== 1'b0) begin
      n_fail++;
      $display("FAIL key_toggle_off: CalcActive got %b expected 0", CalcActive);
    end
    send_key(4'b1010, 1'b0);
    n_chk++;
    if (CalcActive !== 1'b1) begin
      n_fail++;
      $display("FAIL key_toggle_on: CalcActive got %b expected 1", CalcActive);
    end
  endtask

  task automatic test_write_shrink();
    MemSize = 4'd8;
    for (int a = 0; a < 7; a++) op_write(3'(a), 1'b1, "fill7");
    n_chk++;
    if (MemCount !== 4'd7) begin
      n_fail++;
      $display("FAIL count_after_7_writes: got %0d expected 7", MemCount);
    end
    MemSize = 4'd4;
    tick();
    n_chk++;
    if (MemCount !== 4'd4) begin
      n_fail++;
      $display("FAIL count_after_shrink: got %0d expected 4", MemCount);
    end
    op_write(3'd5, 1'b0, "shrink_oob");
    op_write(3'd3, 1'b1, "shrink_rewrite");
    n_chk++;
    if (MemCount !== 4'd4) begin
      n_fail++;
      $display("FAIL count_after_rewrite: got %0d expected 4", MemCount);
    end
  endtask

  task automatic test_fill_drain();
    MemSize = 4'd0;  // zero selects full depth
    tick();
    for (int a = 0; a < 8; a++) op_write(3'(a), 1'b1, "fill8");
    n_chk++;
    if (MemCount !== 4'd8) begin
      n_fail++;
      $display("FAIL count_full: got %0d expected 8", MemCount);
    end
    tx_seen = 0;
    for (int a = 0; a < 8; a++) op_read(3'(a), 1'b1, "drain");
    n_chk++;
    if (tx_seen != 8 || MemCount !== 4'd0) begin
      n_fail++;
      $display("FAIL drain: StartTx pulses/MemCount got %0d/%0d expected 8/0", tx_seen, MemCount);
    end
    op_read(3'd0, 1'b0, "reread0");
    op_read(3'd7, 1'b0, "reread7");
    n_chk++;
    if (tx_seen != 8) begin
      n_fail++;
      $display("FAIL invalid_reads_tx: StartTx pulses got %0d expected 8", tx_seen);
    end
  endtask

  task automatic test_reset_mid_write();
    op_write(3'd4, 1'b1, "pre_reset");
    n_chk++;
    if (MemCount !== 4'd1) begin
      n_fail++;
      $display("FAIL pre_reset_count: got %0d expected 1", MemCount);
    end
    ValidCmd = 1'b1; ModeSel = 1'b1; RWMem = 1'b1; Addr = 3'd1;
    tick();
    ValidCmd = 1'b0;
    n_chk++;
    if (AluEn !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_write_aluen: got %b expected 1", AluEn);
    end
    Reset = 1'b0;
    #1;
    n_chk++;
    if (outs() !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_async: outputs got %h expected 0000", outs());
    end
    tick();
    n_chk++;
    if (outs() !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_hold_no_wr: outputs got %h expected 0000", outs());
    end
    Reset = 1'b1;
    tick();
    send_key(4'b1010, 1'b0);
    n_chk++;
    if (CalcActive !== 1'b1 || MemCount !== 4'd0) begin
      n_fail++;
      $display("FAIL reunlock: CalcActive/MemCount got %b/%0d expected 1/0", CalcActive, MemCount);
    end
    op_read(3'd4, 1'b0, "read_after_reset");
  endtask

  task automatic test_mode_cross();
    op_mode0("cross_m0", 1'b1);
    op_write(3'd2, 1'b1, "cross_wr");
    op_read(3'd2, 1'b1, "cross_rd");
    op_mode0("cross_m0_abort", 1'b0);
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (Busy !== 1'b0 || StartTx !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_3cyc %0d: Busy/StartTx got %b/%b expected 0/0", i, Busy, StartTx);
      end
    end
    Reset = 1'b1;
    TxDone = 1'b1;
    tick();
    TxDone = 1'b0;
    tick();
    n_chk++;
    if (outs() !== 15'h0) begin
      n_fail++;
      $display("FAIL after_reset_3cyc: outputs got %h expected 0000", outs());
    end
  endtask

  initial begin
    test_reset();
    test_unlock_sample();
    test_key_crossing();
    test_write_shrink();
    test_fill_drain();
    test_reset_mid_write();
    test_mode_cross();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
- Control unit of the calculator.
- Unlocks the calculator on a serial key sequence and accepts one command at a time.
- Sequences the ALU, the result memory and the serial transmitter for Mode 0 (compute and transmit), Mode 1 write (compute and store) and Mode 1 read (fetch and transmit).
- Tracks which memory slots hold valid results and signals illegal accesses.

Parameters:
- KEY_SEQ, 4'b1010, unlock/lock sequence on InputKey (MSB received first).
- MEM_DEPTH, 8, physical result memory depth.
- ADDR_W, 3, address width; MEM_DEPTH <= 2**ADDR_W.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- InputKey  in  1  serial key bit, sampled every Clk while IDLE.
- ValidCmd  in  1  command strobe, one cycle.
- ModeSel  in  1  0 = Mode 0, 1 = Mode 1.
- RWMem  in  1  Mode 1 only: 1 = write, 0 = read.
- Addr  in  ADDR_W  memory address for the command.
- MemSize  in  ADDR_W+1  active memory size. 0 or >MEM_DEPTH means MEM_DEPTH.
- TxDone  in  1  serializer finished, one-cycle pulse.
- CalcActive  out  1  calculator unlocked.
- CalcMode  out  1  registered mode.
- Busy  out  1  command in progress.
- AluEn  out  1  ALU capture strobe.
- MemWrEn  out  1  memory write strobe.
- MemRdEn  out  1  memory read strobe.
- MemAddr  out  ADDR_W  registered command address.
- SampleData  out  1  output register load strobe.
- StartTx  out  1  serializer start strobe.
- MemCount  out  ADDR_W+1  number of valid slots.
- AccErr  out  1  illegal access, one-cycle pulse.

Behaviour:
- Reset (Reset=0), immediate and asynchronous:
  - all outputs 0, state IDLE.
  - key shift register 0, valid bitmap 0.
  - reset mid-operation aborts the command with no further strobes.
- States: IDLE, EXEC, MEM_WR, MEM_RD, SAMPLE, TX_START, TX_WAIT.
- Busy = (state != IDLE), registered.
- Strobes (AluEn, MemWrEn, MemRdEn, SampleData, StartTx, AccErr) are registered and high exactly one cycle.
- IDLE behaviour:
  - Key register shifts in InputKey every cycle.
  - When the 4-bit register equals KEY_SEQ, CalcActive toggles next cycle and the register clears.
  - CalcMode <= ModeSel.
- Command acceptance: ValidCmd is accepted only in IDLE with CalcActive=1.
  - ValidCmd while Busy or locked is dropped.
  - Key match and ValidCmd in the same cycle: the toggle wins and the command is dropped.
- On acceptance, MemAddr <= Addr, then:
  - Mode 0: EXEC (AluEn) -> SAMPLE (SampleData) -> TX_START (StartTx) -> TX_WAIT.
  - StartTx is asserted exactly the cycle after SampleData.
- Mode 1 write: EXEC (AluEn) -> MEM_WR.
  - If Addr < effective MemSize: MemWrEn asserted and valid[Addr] set.
  - Otherwise AccErr asserted and nothing is written.
  - Then IDLE.
  - Rewriting a valid slot overwrites it; MemCount is unchanged.
- Mode 1 read:
  - If Addr < size and valid[Addr]: MEM_RD (MemRdEn, valid[Addr] cleared, data valid next cycle) -> SAMPLE -> TX_START -> TX_WAIT.
  - Else: one MEM_RD cycle with AccErr and no MemRdEn, then IDLE. No SampleData, no StartTx.
- TX_WAIT: stays until TxDone=1, then IDLE. TxDone outside TX_WAIT is ignored.
- Latency: ValidCmd to StartTx is 3 cycles (Mode 0) or 3 cycles (read); ValidCmd to MemWrEn is 2 cycles.
- MemCount = popcount(valid), updated the cycle after the write or read.
- Lowering MemSize clears valid bits at index >= new size on the next cycle; MemCount follows.
- CalcActive toggling off is possible only in IDLE; contents of valid are kept.

Test Plan:
- Unlock and sample:
  - Stimulus: shift 1,0,1,0 on InputKey, then ValidCmd with ModeSel=0.
  - Response: CalcActive=1; AluEn at +1, SampleData at +2, StartTx at +3; Busy stays 1 until TxDone, then 0.
- Key crossing:
  - Stimulus: ValidCmd before the key; then 1,0,1,1; then 1,0,1,0.
  - Response: no strobes until the valid key; after the valid key, CalcActive=1. Key 1,0,1,0 again drops CalcActive to 0.
- Write, then shrink memory:
  - Stimulus: Mode 1 writes to Addr 0..6 with MemSize=8; then MemSize=4 and one write to Addr 5.
  - Response: MemCount=7, then 4; the write to Addr 5 gives AccErr=1 and no MemWrEn. A write to Addr 3 leaves MemCount=4.
- Fill then drain:
  - Stimulus: write 8 slots, then read Addr 0..7, then read Addr 0 again plus one more invalid read.
  - Response: 8 StartTx pulses and MemCount=0; the last 2 reads each give AccErr and no StartTx.
- Reset mid write:
  - Stimulus: Reset=0 the cycle after AluEn in Mode 1 write.
  - Response: no MemWrEn; all outputs and MemCount=0; CalcActive=0. A read afterwards (after unlock) gives AccErr.
- Mode crossing with 3-cycle reset:
  - Stimulus: Mode 0 op, Mode 1 write to Addr 2, Mode 1 read of Addr 2; then Reset=0 for 3 cycles during Mode 0 TX_WAIT.
  - Response: each op's strobes follow the state sequences in Behaviour. During reset, Busy=0 and StartTx=0.
